seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the datapath ALU.
- Keeps the existing 3-bit operation set: ADD, SUB, AND, OR, XOR, SLT, SLTU.
- Adds shifts and RV32M-style multiply/divide/remainder, executed iteratively.
- Uses a start/busy/done handshake, so the multi-cycle controller can stall on long operations while simple operations complete in one cycle.

Parameters:
- WIDTH, 32, operand and result width in bits (≥ 4, power of two).
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; accepted only on an edge where busy=0.
- opc  input  4  operation code, sampled at acceptance.
- srcA  input  WIDTH  operand A, sampled at acceptance.
- srcB  input  WIDTH  operand B, sampled at acceptance.
- busy  output  1  high while an iterative op is in flight.
- done  output  1  one-cycle pulse; w is valid in this cycle.
- w  output  WIDTH  registered result; holds until the next done.
- zero  output  1  ~|w (combinational from registered w).

Behaviour:
- Opcodes 0-6 keep the existing encoding: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5 (signed), SLTU 6 (unsigned).
- New simple opcodes: SLL 7, SRL 8, SRA 9; shift amount is srcB[SHW-1:0] and upper srcB bits are ignored.
- Iterative opcodes: MUL 10 (low WIDTH of product), MULH 11 (high WIDTH of signed×signed), DIV 12, DIVU 13, REM 14, REMU 15.
- All 16 codes are defined; there is no high-Z output.
- Reset: state IDLE, w=0, zero=1, done=0, busy=0. Reset mid-operation aborts it and no done is issued.
- FSM states: IDLE, ITER, FIN. busy = (state != IDLE).
- Simple op, IDLE with start=1: w is written at that edge; done=1 in the next cycle; state stays IDLE. Back-to-back starts every cycle are legal, giving one result per cycle.
- Iterative op, IDLE with start=1: operands are captured as magnitudes with sign flags, and the counter is loaded with WIDTH.
  - IDLE→ITER.
  - ITER runs exactly WIDTH cycles, one shift-add (multiply) or restoring-subtract (divide) step per cycle.
  - ITER→FIN.
  - FIN applies sign correction and special cases, then writes w, and the FSM moves to IDLE with done=1.
- Latency from the sampling edge to the done cycle: 1 for simple ops, WIDTH+2 for iterative ops (34 at WIDTH=32).
- start while busy=1 is ignored, with no queueing. opc/srcA/srcB changes after acceptance have no effect.
- done is a pulse only; w and zero hold their value until the next completion.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH; no carry or overflow outputs.
- Signed DIV/REM signs:
  - Quotient is negated when operand signs differ.
  - Remainder takes the sign of the dividend.
- Divisor zero (overrides in FIN):
  - DIV/DIVU give all-ones.
  - REM/REMU give srcA.
  - The op still takes the full WIDTH+2 latency.
- Signed overflow (srcA = most-negative, srcB = -1): DIV gives most-negative, REM gives 0.
- MUL and MULH share the same iteration; the signed 2·WIDTH product is formed in FIN.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (ALU_ADD … ALU_REMU, 4-bit);
  - FSM state encoding (IDLE/ITER/FIN);
  - the is_iterative(opc) function.
- Sub-module iter_muldiv holds the iteration datapath:
  - accumulator, multiplier/quotient shift register, counter, and per-cycle step;
  - it is controlled by load/step/fin strobes from seq_alu.
- The simple-op combinational result stays in seq_alu.

Test Plan:
- Reset and simple ops:
  - Reset held 2 cycles → w=0, zero=1, busy=0, done=0.
  - Then SUB 5,5 → done next cycle, w=0, zero=1.
  - SLT 0xFFFFFFFF,1 → w=1; SLTU with the same operands → w=0.
  - SRA 0x80000000 with srcB=0x24 (shift 4) → w=0xF8000000.
- Iterative MUL/MULH:
  - MUL 0xFFFFFFFF × 0xFFFFFFFF → busy for 33 cycles, done exactly 34 cycles after start, w=1.
  - MULH with the same operands → w=0.
  - MULH 0x7FFFFFFF × 0x7FFFFFFF → w=0x3FFFFFFF.
- Divide signs and zero divisor:
  - DIV -7 / 2 → w=0xFFFFFFFD (-3); REM -7, 2 → 0xFFFFFFFF (-1).
  - DIVU 7 / 0 → 0xFFFFFFFF; REMU 7, 0 → 7.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0, zero=1.
- Handshake:
  - Start DIVU, then pulse start with ADD at cycle 5 → ADD ignored, one done at cycle 34.
  - ADD 1,2 issued in the done cycle → accepted, done next cycle with w=3.
- Reset mid-op: rst at cycle 10 of MUL → no done, busy=0 next cycle, w=0.
- Repeat the MUL/DIV scenarios at WIDTH=8: latency 10, e.g. DIV 0x80 / 0xFF → 0x80.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM states and
// the opcode classification helpers used by the controller and the iterator.
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;
   localparam logic [3:0] ALU_MUL  = 4'd10;
   localparam logic [3:0] ALU_MULH = 4'd11;
   localparam logic [3:0] ALU_DIV  = 4'd12;
   localparam logic [3:0] ALU_DIVU = 4'd13;
   localparam logic [3:0] ALU_REM  = 4'd14;
   localparam logic [3:0] ALU_REMU = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   // Everything from MUL upwards goes through the iterative datapath.
   function automatic logic is_iterative(input logic [3:0] op);
      return (op >= ALU_MUL);
   endfunction

   function automatic logic is_signed_md(input logic [3:0] op);
      return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
   endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative multiply/divide datapath: one shift-add or restoring-subtract
// step per cycle on operand magnitudes, with sign fix-up applied at finish.
module iter_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic             fin,
   input  logic [3:0]       opc,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             last,
   output logic [WIDTH-1:0] res
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, dv_q, dv_d;
   logic [3:0]       op_q, op_d;
   logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d, b_zero_q, b_zero_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   sum, shifted, diff;
   logic             sgn;

   always_comb begin
      acc_d    = acc_q;
      mq_d     = mq_q;
      dv_d     = dv_q;
      op_d     = op_q;
      a_neg_d  = a_neg_q;
      b_neg_d  = b_neg_q;
      b_zero_d = b_zero_q;
      cnt_d    = cnt_q;
      sum      = '0;
      shifted  = '0;
      diff     = '0;
      sgn      = is_signed_md(opc);
      if (load) begin
         a_neg_d  = sgn & src_a[WIDTH-1];
         b_neg_d  = sgn & src_b[WIDTH-1];
         acc_d    = '0;
         mq_d     = a_neg_d ? -src_a : src_a;
         dv_d     = b_neg_d ? -src_b : src_b;
         b_zero_d = (src_b == '0);
         op_d     = opc;
         cnt_d    = CW'(WIDTH);
      end else if (step) begin
         cnt_d = cnt_q - CW'(1);
         if ((op_q == ALU_MUL) || (op_q == ALU_MULH)) begin
            // {carry, acc, mq} shifts right as one register after the add.
            sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, dv_q} : '0);
            acc_d = sum[WIDTH:1];
            mq_d  = {sum[0], mq_q[WIDTH-1:1]};
         end else begin
            shifted = {acc_q, mq_q[WIDTH-1]};
            diff    = shifted - {1'b0, dv_q};
            if (!diff[WIDTH]) begin
               acc_d = diff[WIDTH-1:0];
               mq_d  = {mq_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = shifted[WIDTH-1:0];
               mq_d  = {mq_q[WIDTH-2:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      dv_q     <= dv_d;
      op_q     <= op_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      b_zero_q <= b_zero_d;
   end

   assign last = (cnt_q == CW'(1));

   logic [2*WIDTH-1:0] prod, prod_s;
   logic [WIDTH-1:0]   quo_s, rem_s, res_raw;

   // A zero divisor leaves the remainder magnitude equal to |srcA|, so the
   // dividend-sign fix-up already reproduces srcA for REM/REMU.
   always_comb begin
      prod    = {acc_q, mq_q};
      prod_s  = (a_neg_q ^ b_neg_q) ? -prod : prod;
      quo_s   = (a_neg_q ^ b_neg_q) ? -mq_q : mq_q;
      rem_s   = a_neg_q ? -acc_q : acc_q;
      res_raw = '0;
      case (op_q)
         ALU_MUL:            res_raw = prod_s[WIDTH-1:0];
         ALU_MULH:           res_raw = prod_s[2*WIDTH-1:WIDTH];
         ALU_DIV, ALU_DIVU:  res_raw = b_zero_q ? '1 : quo_s;
         ALU_REM, ALU_REMU:  res_raw = rem_s;
         default:            res_raw = '0;
      endcase
      res = fin ? res_raw : '0;
   end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle simple ops plus iterative mul/div behind a
// start/busy/done handshake.
module seq_alu
   import alu_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       opc,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] w,
   output logic             zero
);

   state_t                  state_q, state_d;
   logic [WIDTH-1:0]        w_q, w_d;
   logic                    done_q, done_d;
   logic                    md_load, md_step, md_fin, md_last;
   logic [WIDTH-1:0]        md_res, simple;
   logic signed [WIDTH-1:0] a_s, b_s;
   logic [SHW-1:0]          shamt;

   iter_muldiv #(.WIDTH(WIDTH)) u_md (
      .clk   (clk),
      .rst   (rst),
      .load  (md_load),
      .step  (md_step),
      .fin   (md_fin),
      .opc   (opc),
      .src_a (srcA),
      .src_b (srcB),
      .last  (md_last),
      .res   (md_res)
   );

   always_comb begin
      a_s    = srcA;
      b_s    = srcB;
      shamt  = srcB[SHW-1:0];
      simple = '0;
      case (opc)
         ALU_ADD:  simple = srcA + srcB;
         ALU_SUB:  simple = srcA - srcB;
         ALU_AND:  simple = srcA & srcB;
         ALU_OR:   simple = srcA | srcB;
         ALU_XOR:  simple = srcA ^ srcB;
         ALU_SLT:  simple = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
         ALU_SLTU: simple = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
         ALU_SLL:  simple = srcA << shamt;
         ALU_SRL:  simple = srcA >> shamt;
         ALU_SRA:  simple = a_s >>> shamt;
         default:  simple = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      done_d  = 1'b0;
      md_load = 1'b0;
      md_step = 1'b0;
      md_fin  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (is_iterative(opc)) begin
                  md_load = 1'b1;
                  state_d = ST_ITER;
               end else begin
                  w_d    = simple;
                  done_d = 1'b1;
               end
            end
         end
         ST_ITER: begin
            md_step = 1'b1;
            if (md_last) state_d = ST_FIN;
         end
         ST_FIN: begin
            md_fin  = 1'b1;
            w_d     = md_res;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         w_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign w    = w_q;
   assign zero = ~|w_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32 and WIDTH=8 with hand-computed results.
module tb_seq_alu;
   import alu_pkg::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start32, start8;
   logic [3:0]  opc;
   logic [31:0] src_a, src_b;
   logic        busy32, done32, zero32, busy8, done8, zero8;
   logic [31:0] w32;
   logic [7:0]  w8;

   int n_cmp = 0;
   int n_err = 0;

   seq_alu #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .start(start32), .opc(opc), .srcA(src_a), .srcB(src_b),
      .busy(busy32), .done(done32), .w(w32), .zero(zero32));

   seq_alu #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .opc(opc), .srcA(src_a[7:0]), .srcB(src_b[7:0]),
      .busy(busy8), .done(done8), .w(w8), .zero(zero8));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op and wait (bounded) for done; lat counts edges from the sampling edge.
   task automatic run_op(input bit use8, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat, output int bcnt,
                         output logic [31:0] res, output logic z);
      @(negedge clk);
      opc = op; src_a = a; src_b = b;
      if (use8) start8 = 1'b1; else start32 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0; start32 = 1'b0;
      lat = 1; bcnt = 0;
      while (!(use8 ? done8 : done32) && lat < 200) begin
         if (use8 ? busy8 : busy32) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
      res = use8 ? {24'h0, w8} : w32;
      z   = use8 ? zero8 : zero32;
   endtask

   task automatic op_check(input string tag, input bit use8, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int exp_lat);
      int lat, bcnt;
      logic [31:0] res;
      logic z;
      run_op(use8, op, a, b, lat, bcnt, res, z);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_w"}, res, exp);
   endtask

   initial begin
      int lat, bcnt, nd, first;
      logic [31:0] res;
      logic z;

      rst = 1'b1; start32 = 1'b0; start8 = 1'b0; opc = '0; src_a = '0; src_b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_w", w32, 32'h0);
      chk("rst_zero", {31'h0, zero32}, 32'h1);
      chk("rst_busy", {31'h0, busy32}, 32'h0);
      chk("rst_done", {31'h0, done32}, 32'h0);
      chk("rst_w8", {24'h0, w8}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      run_op(0, ALU_SUB, 32'd5, 32'd5, lat, bcnt, res, z);
      chk("sub_lat", lat, 1);
      chk("sub_w", res, 32'h0);
      chk("sub_zero", {31'h0, z}, 32'h1);

      op_check("slt",  0, ALU_SLT,  32'hFFFFFFFF, 32'd1, 32'd1, 1);
      op_check("sltu", 0, ALU_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1);
      op_check("sra",  0, ALU_SRA,  32'h80000000, 32'h24, 32'hF8000000, 1);
      op_check("srl",  0, ALU_SRL,  32'h80000000, 32'h104, 32'h08000000, 1);
      op_check("sll",  0, ALU_SLL,  32'h00000003, 32'h3F, 32'h80000000, 1);
      op_check("add",  0, ALU_ADD,  32'hFFFFFFFF, 32'd2, 32'd1, 1);
      op_check("xor",  0, ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1);

      run_op(0, ALU_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt, res, z);
      chk("mul_lat", lat, 34);
      chk("mul_busy", bcnt, 33);
      chk("mul_w", res, 32'd1);
      op_check("mulh_m1",  0, ALU_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 34);
      op_check("mulh_max", 0, ALU_MULH, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 34);
      op_check("mul_neg",  0, ALU_MUL,  32'd6, 32'hFFFFFFF9, 32'hFFFFFFD6, 34);

      op_check("div_m7",   0, ALU_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
      op_check("rem_m7",   0, ALU_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
      op_check("divu_z",   0, ALU_DIVU, 32'd7, 32'd0, 32'hFFFFFFFF, 34);
      op_check("remu_z",   0, ALU_REMU, 32'd7, 32'd0, 32'd7, 34);
      op_check("div_z",    0, ALU_DIV,  32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 34);
      op_check("rem_z",    0, ALU_REM,  32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 34);
      op_check("div_ovf",  0, ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34);
      run_op(0, ALU_REM, 32'h80000000, 32'hFFFFFFFF, lat, bcnt, res, z);
      chk("rem_ovf_w", res, 32'h0);
      chk("rem_ovf_zero", {31'h0, z}, 32'h1);

      // Start ignored while busy; opc/src changes after acceptance have no effect.
      @(negedge clk);
      opc = ALU_DIVU; src_a = 32'd100; src_b = 32'd7; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      nd = 0; first = 0;
      for (int cyc = 1; cyc < 45; cyc++) begin
         if (done32) begin
            nd++;
            if (first == 0) first = cyc;
         end
         if (cyc == 5) begin
            opc = ALU_ADD; src_a = 32'd1; src_b = 32'd2; start32 = 1'b1;
         end else begin
            start32 = 1'b0;
         end
         @(posedge clk); #1;
      end
      chk("hs_ndone", nd, 1);
      chk("hs_lat", first, 34);
      chk("hs_w", w32, 32'd14);

      run_op(0, ALU_DIVU, 32'd100, 32'd7, lat, bcnt, res, z);
      chk("divu_w", res, 32'd14);
      op_check("add_in_done", 0, ALU_ADD, 32'd1, 32'd2, 32'd3, 1);

      // Abort a multiply with reset: nothing may complete afterwards.
      @(negedge clk);
      opc = ALU_MUL; src_a = 32'd3; src_b = 32'd5; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", {31'h0, busy32}, 32'h0);
      chk("abort_done", {31'h0, done32}, 32'h0);
      chk("abort_w", w32, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done32) nd++;
      end
      chk("abort_nodone", nd, 0);

      run_op(1, ALU_MUL, 32'hFF, 32'hFF, lat, bcnt, res, z);
      chk("w8_mul_lat", lat, 10);
      chk("w8_mul_busy", bcnt, 9);
      chk("w8_mul_w", res, 32'h01);
      op_check("w8_mulh",  1, ALU_MULH, 32'h7F, 32'h7F, 32'h3F, 10);
      op_check("w8_div",   1, ALU_DIV,  32'h80, 32'hFF, 32'h80, 10);
      op_check("w8_rem",   1, ALU_REM,  32'h80, 32'hFF, 32'h00, 10);
      op_check("w8_divs",  1, ALU_DIV,  32'hF9, 32'h02, 32'hFD, 10);
      op_check("w8_divu",  1, ALU_DIVU, 32'hC8, 32'h0D, 32'h0F, 10);
      op_check("w8_remu",  1, ALU_REMU, 32'hC8, 32'h0D, 32'h05, 10);
      op_check("w8_divz",  1, ALU_DIVU, 32'h07, 32'h00, 32'hFF, 10);
      op_check("w8_sra",   1, ALU_SRA,  32'h80, 32'h0A, 32'hE0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
